// File: rtl/riscv_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, buffers {instr, pc} pairs in a DEPTH-entry FIFO.
// Optional macro RISCV_FETCH_STATS_EN enables the fetch/stall statistic counters.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef IMEM_ADDR_BIT
`define IMEM_ADDR_BIT 12
`endif

module riscv_fetch_queue #(
  parameter logic [`XLEN-1:0] RESET_PC = '0,
  parameter int unsigned      DEPTH    = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  output logic [`XLEN-1:0]  o_imem_addr,
  input  logic [`XLEN-1:0]  i_imem_instr,
  input  logic              i_redirect_valid,
  input  logic [`XLEN-1:0]  i_redirect_pc,
  output logic              o_instr_valid,
  output logic [`XLEN-1:0]  o_instr,
  output logic [`XLEN-1:0]  o_instr_pc,
  input  logic              i_instr_ready,
  output logic [31:0]       o_fetch_cnt,
  output logic [31:0]       o_stall_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [`XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [`XLEN-1:0] mem_instr_q [DEPTH];
  logic [`XLEN-1:0] mem_pc_q    [DEPTH];

  logic pop, push, full;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

  assign full          = (count_q == FULL_CNT);
  assign o_instr_valid = (count_q != '0);
  assign pop           = o_instr_valid & i_instr_ready;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign push          = !i_redirect_valid & (!full | pop);

  assign o_imem_addr = pc_q;
  assign o_instr     = mem_instr_q[rd_ptr_q];
  assign o_instr_pc  = mem_pc_q[rd_ptr_q];

  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_redirect_valid) begin
      pc_d     = {i_redirect_pc[`XLEN-1:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + `XLEN'(4);
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_instr_q[i] <= '0;
        mem_pc_q[i]    <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_instr_q[wr_ptr_q] <= i_imem_instr;
        mem_pc_q[wr_ptr_q]    <= pc_q;
      end
    end
  end

`ifdef RISCV_FETCH_STATS_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (push) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (full && !pop && !i_redirect_valid) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_fetch_cnt = fetch_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`else
  assign o_fetch_cnt = '0;
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Bench for riscv_fetch_queue: directed scenarios plus randomized traffic vs. a queue-based model.
`ifndef XLEN
`define XLEN 32
`endif

module tb_riscv_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_instr;
  logic        i_redirect_valid = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_instr_valid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        i_instr_ready = 1'b0;
  logic [31:0] o_fetch_cnt;
  logic [31:0] o_stall_cnt;

  riscv_fetch_queue #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .i_clk           (i_clk),
    .i_rstn          (i_rstn),
    .o_imem_addr     (o_imem_addr),
    .i_imem_instr    (i_imem_instr),
    .i_redirect_valid(i_redirect_valid),
    .i_redirect_pc   (i_redirect_pc),
    .o_instr_valid   (o_instr_valid),
    .o_instr         (o_instr),
    .o_instr_pc      (o_instr_pc),
    .i_instr_ready   (i_instr_ready),
    .o_fetch_cnt     (o_fetch_cnt),
    .o_stall_cnt     (o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  assign i_imem_instr = imem_word(o_imem_addr);

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;
  bit          m_clear;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Advance the model by one clock using the inputs about to be applied.
  task automatic model_step(input bit rst_n, input bit redir, input logic [31:0] rpc, input bit ready);
    bit pop, push;
    if (!rst_n) begin
      mq.delete();
      m_pc = RST_PC; m_fetch = 0; m_stall = 0; m_clear = 1;
      return;
    end
    pop  = (mq.size() > 0) && ready;
    push = !redir && ((mq.size() < DEPTH) || pop);
    if (mq.size() == DEPTH && !pop && !redir) m_stall++;
    if (redir) begin
      mq.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back('{instr: imem_word(m_pc), pc: m_pc});
        m_pc += 4; m_fetch++; m_clear = 0;
      end
    end
  endtask

  task automatic compare_model();
    chk("imem_addr", o_imem_addr, m_pc);
    chk("instr_valid", {31'b0, o_instr_valid}, {31'b0, mq.size() > 0});
    if (mq.size() > 0) begin
      chk("instr", o_instr, mq[0].instr);
      chk("instr_pc", o_instr_pc, mq[0].pc);
    end else if (m_clear) begin
      chk("instr_clr", o_instr, 32'h0);
      chk("instr_pc_clr", o_instr_pc, 32'h0);
    end
`ifdef RISCV_FETCH_STATS_EN
    chk("fetch_cnt", o_fetch_cnt, m_fetch);
    chk("stall_cnt", o_stall_cnt, m_stall);
`else
    chk("fetch_cnt", o_fetch_cnt, 32'h0);
    chk("stall_cnt", o_stall_cnt, 32'h0);
`endif
  endtask

  task automatic step(input bit rst_n, input bit redir, input logic [31:0] rpc, input bit ready);
    i_rstn = rst_n; i_redirect_valid = redir; i_redirect_pc = rpc; i_instr_ready = ready;
    model_step(rst_n, redir, rpc, ready);
    @(posedge i_clk);
    #1;
    compare_model();
  endtask

  initial begin
    @(posedge i_clk); #1;
    // Reset release, streaming at one instruction per cycle.
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_addr", o_imem_addr, 32'h0);
    chk("rst_valid", {31'b0, o_instr_valid}, 32'h0);
    chk("rst_instr", o_instr, 32'h0);
    step(1, 0, 0, 1);
    chk("first_valid", {31'b0, o_instr_valid}, 32'h1);
    chk("first_instr", o_instr, 32'h1000_0000);
    chk("first_pc", o_instr_pc, 32'h0);
    chk("first_addr", o_imem_addr, 32'h4);
    step(1, 0, 0, 1);
    chk("second_pc", o_instr_pc, 32'h4);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1);

    // Fill and stall, then same-cycle replace and drain.
    step(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    chk("full_addr", o_imem_addr, 32'd16);
    chk("full_head", o_instr_pc, 32'd0);
`ifdef RISCV_FETCH_STATS_EN
    chk("stall6", o_stall_cnt, 32'd6);
`endif
    step(1, 0, 0, 1);
    chk("replace_head", o_instr_pc, 32'd4);
    chk("replace_addr", o_imem_addr, 32'd20);
    chk("replace_tail", mq[DEPTH-1].pc, 32'd16);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1);

    // Redirect with three entries queued, target LSBs ignored.
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(1, 1, 32'h0000_0103, 0);
    chk("redir_valid", {31'b0, o_instr_valid}, 32'h0);
    chk("redir_addr", o_imem_addr, 32'h100);
    step(1, 0, 0, 0);
    chk("redir_head_pc", o_instr_pc, 32'h100);

    // Back-to-back redirects: last one wins.
    step(1, 1, 32'h200, 1);
    step(1, 1, 32'h300, 1);
    step(1, 0, 0, 1);
    chk("b2b_pc", o_instr_pc, 32'h300);
    chk("b2b_valid", {31'b0, o_instr_valid}, 32'h1);

    // Reset beats a redirect on a full queue.
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    step(0, 1, 32'h400, 1);
    chk("rstwin_valid", {31'b0, o_instr_valid}, 32'h0);
    chk("rstwin_addr", o_imem_addr, RST_PC);
    chk("rstwin_fetch", o_fetch_cnt, 32'h0);
    chk("rstwin_stall", o_stall_cnt, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit          r, rd, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 199) != 0);
      rd  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      rpc = $urandom;
      step(r, rd, rpc, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
